fighter_action_fsm: RTL and testbench
=====================================

# fighter_action_fsm

Per-player action state machine between the USB keycode register and PlayerControl/color_mapper. Samples the 8-bit HID keycode once per video frame, on the rising edge of VGA vertical sync, and sequences IDLE/WALK/JUMP/PUNCH/KICK/HITSTUN with per-action animation frame counters. It also produces the jump height offset, a per-frame walk step and the attack-active window. There is one instance per player; only the key-code parameters differ between instances.

## Interface
Parameters:
- KEY_LEFT, 8'h04: HID code for move left (P1 A).
- KEY_RIGHT, 8'h07: move right (P1 D).
- KEY_JUMP, 8'h1A: jump (P1 W).
- KEY_PUNCH, 8'h09: punch (P1 F).
- KEY_KICK, 8'h0A: kick (P1 G).
- JUMP_V0, 10: initial jump velocity, in pixels per frame.
- PUNCH_FRAMES, 12: punch duration, in frames.
- KICK_FRAMES, 16: kick duration, in frames.
- HIT_FRAMES, 10: hit-stun duration, in frames.
- INIT_FACE_RIGHT, 1: facing value after reset.

Ports:
- Clk, input, 1: 50 MHz system clock, same clock as vga_controller.
- Reset, input, 1: synchronous, active-high.
- vs, input, 1: VGA_VS, synchronous to Clk.
- keycode, input, 8: current HID keycode; 0 means no key.
- hit_in, input, 1: one-cycle pulse from collision logic.
- action, output, 3: current action_e.
- anim_frame, output, 4: frame index within the current action; saturates at 15.
- y_off, output, 7: jump height above ground, unsigned.
- step, output, 2: signed walk step for this frame (−1, 0 or +1); valid only while frame_tick is high.
- facing_right, output, 1: current facing direction.
- attack_active, output, 1: punch or kick hitbox is live.
- frame_tick, output, 1: one-cycle pulse, once per frame.

## Operation
- Tick generation: vs_d1 and vs_d2 are registers; frame_tick = vs_d1 & ~vs_d2. All state updates happen only on edges where frame_tick = 1.
- press_edge: keycode ≠ keycode_prev. keycode_prev is the keycode latched at the previous tick.
- Attacks require press_edge. Walk and jump are level-sensitive.
- State decisions at a tick:
  - IDLE/WALK, evaluated in priority order:
    1. hit_pending → HITSTUN.
    2. keycode == KEY_JUMP → JUMP. Load vel = JUMP_V0, y_off = 0.
    3. KEY_PUNCH with press_edge → PUNCH.
    4. KEY_KICK with press_edge → KICK.
    5. KEY_LEFT or KEY_RIGHT → WALK. Set step to −1 or +1 and update facing_right.
    6. Otherwise → IDLE.
  - JUMP:
    - If y_off + vel ≤ 0 (signed 9-bit): y_off = 0, go to IDLE.
    - Otherwise: y_off += vel, vel −= 1.
    - Left/right keys still produce a step but do not change facing.
    - hit_in is ignored while airborne.
  - PUNCH/KICK: anim_frame increments each tick. After PUNCH_FRAMES or KICK_FRAMES ticks, go to IDLE. hit_pending aborts to HITSTUN.
  - HITSTUN: lasts HIT_FRAMES ticks, then goes to IDLE. hit_in received during HITSTUN does not restart the count.
- hit_pending: set by hit_in at any cycle, cleared at the next tick.
  - If hit_in arrives on the same cycle as a tick, it takes effect at that tick.
  - hit_pending is discarded when the player is in JUMP or HITSTUN.
- anim_frame resets to 0 on every action change.
- attack_active is high while anim_frame is in 4..7, in PUNCH or KICK only.
- step is 0 in any state other than WALK or JUMP.

## Timing
- Reset values:
  - action = IDLE; anim_frame, y_off, step and attack_active = 0.
  - facing_right = INIT_FACE_RIGHT.
  - vel, keycode_prev, hit_pending, vs_d1 and vs_d2 = 0.
  - Reset mid-jump returns y_off to 0 on the next edge.
- frame_tick is high on the second Clk edge after vs rises. Outputs reflect the decision on the edge after that: 2 cycles of latency from sampling to output.
- Outputs are held constant between ticks. step is qualified by frame_tick.
- A keycode change between ticks is invisible to the FSM. Only the value present at the tick counts.

## Structure
- fighter_pkg contains:
  - action_e = {IDLE, WALK, JUMP, PUNCH, KICK, HITSTUN}.
  - Default HID key constants for P1 and P2; P2 uses arrow keys 0x50/0x4F/0x52 and L/K.
  - Constants ATTACK_ACTIVE_FIRST = 4 and ATTACK_ACTIVE_LAST = 7.
- Sub-module jump_arc holds the vel and y_off registers and signed landing compare. Its interface is start, tick, y_off, landed.

## Test plan
- Jump with JUMP_V0 = 10, holding 0x1A: y_off per tick follows 10, 19, 27, 34, 40, 45, 49, 52, 54, 55, 55, 54, 52, 49, 45, 40, 34, 27, 19, 10. The landing tick sets y_off = 0 and action = IDLE.
- Punch: 0x09 pressed at a tick → PUNCH. attack_active is high for ticks 4–7 only. Holding 0x09 returns to IDLE after 12 ticks and does not retrigger, because there is no new press_edge.
- Walk left: 0x04 held for 5 ticks → step = −1 on each of the 5 frame_tick cycles and facing_right = 0. Releasing the key → IDLE, step = 0.
- Hit during kick at tick 3 → HITSTUN for 10 ticks, then IDLE. A second hit_in during HITSTUN does not extend it. hit_in mid-jump is ignored.
- Simultaneous events: hit_in on the same cycle as a tick, with 0x1A held → HITSTUN wins.
- Reset asserted mid-jump with y_off = 40 → all outputs return to their reset values after one edge.

Source files
------------

// File: rtl/fighter_pkg.sv
// fighter_pkg
// Shared types and constants for the per-player action state machine:
//   action_e            - encoding of the player's current action
//   P1_* / P2_* keys    - default USB HID keycodes for each player
//   ATTACK_ACTIVE_*     - anim_frame window in which a punch/kick hitbox is live
package fighter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WALK    = 3'd1,
    JUMP    = 3'd2,
    PUNCH   = 3'd3,
    KICK    = 3'd4,
    HITSTUN = 3'd5
  } action_e;

  // Player 1: A / D / W / F / G
  localparam logic [7:0] P1_KEY_LEFT  = 8'h04;
  localparam logic [7:0] P1_KEY_RIGHT = 8'h07;
  localparam logic [7:0] P1_KEY_JUMP  = 8'h1A;
  localparam logic [7:0] P1_KEY_PUNCH = 8'h09;
  localparam logic [7:0] P1_KEY_KICK  = 8'h0A;

  // Player 2: arrow keys for movement, L / K for attacks
  localparam logic [7:0] P2_KEY_LEFT  = 8'h50;
  localparam logic [7:0] P2_KEY_RIGHT = 8'h4F;
  localparam logic [7:0] P2_KEY_JUMP  = 8'h52;
  localparam logic [7:0] P2_KEY_PUNCH = 8'h0F;
  localparam logic [7:0] P2_KEY_KICK  = 8'h0E;

  localparam int ATTACK_ACTIVE_FIRST = 4;
  localparam int ATTACK_ACTIVE_LAST  = 7;

  // True when an attack animation frame lies inside the live-hitbox window.
  function automatic logic in_attack_window(input logic [3:0] frame);
    return (frame >= 4'(ATTACK_ACTIVE_FIRST)) && (frame <= 4'(ATTACK_ACTIVE_LAST));
  endfunction

endpackage

// File: rtl/fighter_action_fsm_jump_arc.sv
// jump_arc
// Ballistic jump height generator. On start the vertical velocity is loaded
// with JUMP_V0 and the height cleared; on every tick the height advances by
// the velocity and the velocity drops by one pixel/frame. landed flags that
// the next tick would put the player at or below the ground.
// Ports:
//   Clk, Reset - clock and synchronous active-high reset
//   start      - load initial velocity, height = 0 (has priority over tick)
//   tick       - advance one frame of the arc
//   y_off      - current height above ground (unsigned pixels)
//   landed     - y_off + vel <= 0 (signed), i.e. this tick is the landing tick
module jump_arc #(
  parameter int JUMP_V0 = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       tick,
  output logic [6:0] y_off,
  output logic       landed
);

  logic signed [7:0] vel_q, vel_d;
  logic [6:0]        y_off_q, y_off_d;
  logic signed [8:0] sum;

  // 9-bit signed sum so the descending half can go negative without wrapping.
  assign sum    = $signed({2'b00, y_off_q}) + $signed({vel_q[7], vel_q});
  assign landed = (sum <= 9'sd0);

  always_comb begin
    vel_d   = vel_q;
    y_off_d = y_off_q;
    if (start) begin
      vel_d   = 8'(JUMP_V0);
      y_off_d = 7'd0;
    end else if (tick) begin
      if (landed) begin
        y_off_d = 7'd0;
      end else begin
        y_off_d = sum[6:0];
        vel_d   = vel_q - 8'sd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vel_q   <= '0;
      y_off_q <= '0;
    end else begin
      vel_q   <= vel_d;
      y_off_q <= y_off_d;
    end
  end

  assign y_off = y_off_q;

endmodule

// File: rtl/fighter_action_fsm.sv
// fighter_action_fsm
// Per-player action state machine. The HID keycode is sampled once per video
// frame (rising edge of VGA vsync) and drives IDLE/WALK/JUMP/PUNCH/KICK/HITSTUN
// with per-action animation frame counters, jump height and walk step.
// Ports:
//   Clk, Reset    - 50 MHz clock, synchronous active-high reset
//   vs            - VGA vertical sync (synchronous to Clk)
//   keycode       - current HID keycode, 0 = no key
//   hit_in        - one-cycle hit pulse from collision logic
//   action        - current action_e
//   anim_frame    - frame index within the current action (saturates at 15)
//   y_off         - jump height above ground
//   step          - signed walk step (-1/0/+1), meaningful with frame_tick
//   facing_right  - facing direction
//   attack_active - punch/kick hitbox live
//   frame_tick    - one-cycle pulse per frame
module fighter_action_fsm
  import fighter_pkg::*;
#(
  parameter logic [7:0] KEY_LEFT        = P1_KEY_LEFT,
  parameter logic [7:0] KEY_RIGHT       = P1_KEY_RIGHT,
  parameter logic [7:0] KEY_JUMP        = P1_KEY_JUMP,
  parameter logic [7:0] KEY_PUNCH       = P1_KEY_PUNCH,
  parameter logic [7:0] KEY_KICK        = P1_KEY_KICK,
  parameter int         JUMP_V0         = 10,
  parameter int         PUNCH_FRAMES    = 12,
  parameter int         KICK_FRAMES     = 16,
  parameter int         HIT_FRAMES      = 10,
  parameter logic       INIT_FACE_RIGHT = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       vs,
  input  logic [7:0] keycode,
  input  logic       hit_in,
  output logic [2:0] action,
  output logic [3:0] anim_frame,
  output logic [6:0] y_off,
  output logic [1:0] step,
  output logic       facing_right,
  output logic       attack_active,
  output logic       frame_tick
);

  logic       vs_d1_q, vs_d2_q;
  action_e    action_q, action_d;
  logic [3:0] anim_q, anim_d;
  logic [1:0] step_q, step_d;
  logic       facing_q, facing_d;
  logic [7:0] keycode_prev_q, keycode_prev_d;
  logic       hit_pending_q, hit_pending_d;
  logic       press_edge, hit_now;
  logic       jump_start, jump_tick, jump_landed;

  assign frame_tick = vs_d1_q & ~vs_d2_q;
  assign press_edge = (keycode != keycode_prev_q);
  // A hit arriving on the tick cycle itself counts for that tick.
  assign hit_now    = hit_pending_q | hit_in;

  jump_arc #(.JUMP_V0(JUMP_V0)) u_jump_arc (
    .Clk    (Clk),
    .Reset  (Reset),
    .start  (jump_start),
    .tick   (jump_tick),
    .y_off  (y_off),
    .landed (jump_landed)
  );

  always_comb begin
    action_d       = action_q;
    anim_d         = anim_q;
    step_d         = step_q;
    facing_d       = facing_q;
    keycode_prev_d = keycode_prev_q;
    hit_pending_d  = hit_pending_q | hit_in;
    jump_start     = 1'b0;
    jump_tick      = 1'b0;

    if (frame_tick) begin
      keycode_prev_d = keycode;
      hit_pending_d  = 1'b0;
      step_d         = 2'b00;
      case (action_q)
        IDLE, WALK: begin
          if (hit_now) begin
            action_d = HITSTUN;
          end else if (keycode == KEY_JUMP) begin
            action_d   = JUMP;
            jump_start = 1'b1;
          end else if (keycode == KEY_PUNCH && press_edge) begin
            action_d = PUNCH;
          end else if (keycode == KEY_KICK && press_edge) begin
            action_d = KICK;
          end else if (keycode == KEY_LEFT) begin
            action_d = WALK;
            step_d   = 2'b11;
            facing_d = 1'b0;
          end else if (keycode == KEY_RIGHT) begin
            action_d = WALK;
            step_d   = 2'b01;
            facing_d = 1'b1;
          end else begin
            action_d = IDLE;
          end
        end
        JUMP: begin
          // Airborne: hits ignored, steering allowed without turning around.
          jump_tick = 1'b1;
          if (jump_landed) begin
            action_d = IDLE;
          end else if (keycode == KEY_LEFT) begin
            step_d = 2'b11;
          end else if (keycode == KEY_RIGHT) begin
            step_d = 2'b01;
          end
        end
        PUNCH: begin
          if (hit_now)                                action_d = HITSTUN;
          else if (anim_q == 4'(PUNCH_FRAMES - 1))    action_d = IDLE;
        end
        KICK: begin
          if (hit_now)                                action_d = HITSTUN;
          else if (anim_q == 4'(KICK_FRAMES - 1))     action_d = IDLE;
        end
        HITSTUN: begin
          if (anim_q == 4'(HIT_FRAMES - 1))           action_d = IDLE;
        end
        default: action_d = IDLE;
      endcase

      if (action_d != action_q)  anim_d = 4'd0;
      else if (anim_q != 4'd15)  anim_d = anim_q + 4'd1;
    end else if (action_q == JUMP || action_q == HITSTUN) begin
      // Hits landing on an airborne or already-stunned player are dropped.
      hit_pending_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_d1_q        <= 1'b0;
      vs_d2_q        <= 1'b0;
      action_q       <= IDLE;
      anim_q         <= 4'd0;
      step_q         <= 2'b00;
      facing_q       <= INIT_FACE_RIGHT;
      keycode_prev_q <= 8'h00;
      hit_pending_q  <= 1'b0;
    end else begin
      vs_d1_q        <= vs;
      vs_d2_q        <= vs_d1_q;
      action_q       <= action_d;
      anim_q         <= anim_d;
      step_q         <= step_d;
      facing_q       <= facing_d;
      keycode_prev_q <= keycode_prev_d;
      hit_pending_q  <= hit_pending_d;
    end
  end

  assign action        = action_q;
  assign anim_frame    = anim_q;
  assign step          = step_q;
  assign facing_right  = facing_q;
  assign attack_active = ((action_q == PUNCH) || (action_q == KICK)) && in_attack_window(anim_q);

endmodule

// File: tb/tb_fighter_action_fsm.sv
// Scoreboard bench for fighter_action_fsm: stimulus pushes the expected
// post-tick outputs from a frame-level reference model; a monitor pops and
// compares after every frame_tick decision edge.
module tb_fighter_action_fsm;
  import fighter_pkg::*;

  localparam int V0 = 10, PF = 12, KF = 16, HF = 10;

  logic       Clk = 1'b0, Reset = 1'b1, vs = 1'b0, hit_in = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [2:0] action;
  logic [3:0] anim_frame;
  logic [6:0] y_off;
  logic [1:0] step;
  logic       facing_right, attack_active, frame_tick;

  fighter_action_fsm dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .vs            (vs),
    .keycode       (keycode),
    .hit_in        (hit_in),
    .action        (action),
    .anim_frame    (anim_frame),
    .y_off         (y_off),
    .step          (step),
    .facing_right  (facing_right),
    .attack_active (attack_active),
    .frame_tick    (frame_tick)
  );

  always #10 Clk = ~Clk;

  typedef struct packed {
    logic [2:0] act;
    logic [3:0] anim;
    logic [6:0] y;
    logic [1:0] st;
    logic       face;
    logic       atk;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_ticks = 0;

  // Frame-level reference model state
  action_e    m_act;
  int         m_age;   // ticks spent in current action
  int         m_n;     // ticks since jump take-off
  int         m_y, m_step;
  logic       m_face;
  logic [7:0] m_prev;

  function automatic void chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endfunction

  function automatic void model_reset();
    m_act = IDLE; m_age = 0; m_n = 0; m_y = 0; m_step = 0; m_face = 1'b1; m_prev = 8'h00;
  endfunction

  // One frame decision: key is the keycode present at the tick, hit says a
  // hit_in pulse arrived since the previous tick (or on the tick cycle).
  function automatic void model_tick(input logic [7:0] key, input bit hit);
    bit      press   = (key != m_prev);
    bit      hit_eff = hit && (m_act != JUMP) && (m_act != HITSTUN);
    action_e nxt     = m_act;
    int      n, h, anim;
    exp_t    e;
    m_prev = key;
    m_step = 0;
    case (m_act)
      IDLE, WALK: begin
        if (hit_eff)                        nxt = HITSTUN;
        else if (key == 8'h1A)              begin nxt = JUMP; m_n = 0; m_y = 0; end
        else if (key == 8'h09 && press)     nxt = PUNCH;
        else if (key == 8'h0A && press)     nxt = KICK;
        else if (key == 8'h04)              begin nxt = WALK; m_step = -1; m_face = 1'b0; end
        else if (key == 8'h07)              begin nxt = WALK; m_step = 1;  m_face = 1'b1; end
        else                                nxt = IDLE;
      end
      JUMP: begin
        // closed-form height after n frames of the arc
        n = m_n + 1;
        h = n * V0 - (n * (n - 1)) / 2;
        if (h <= 0) begin
          nxt = IDLE; m_y = 0;
        end else begin
          m_n = n; m_y = h;
          m_step = (key == 8'h04) ? -1 : (key == 8'h07) ? 1 : 0;
        end
      end
      PUNCH:   if (hit_eff) nxt = HITSTUN; else if (m_age + 1 >= PF) nxt = IDLE;
      KICK:    if (hit_eff) nxt = HITSTUN; else if (m_age + 1 >= KF) nxt = IDLE;
      HITSTUN: if (m_age + 1 >= HF) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (nxt != m_act) m_age = 0; else m_age++;
    m_act  = nxt;
    anim   = (m_age > 15) ? 15 : m_age;
    e.act  = m_act;
    e.anim = anim[3:0];
    e.y    = m_y[6:0];
    e.st   = m_step[1:0];
    e.face = m_face;
    e.atk  = ((m_act == PUNCH) || (m_act == KICK)) && anim >= 4 && anim <= 7;
    exp_q.push_back(e);
  endfunction

  // Monitor: after each decision edge, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (frame_tick === 1'b1 && Reset === 1'b0) begin
        @(posedge Clk);
        #1;
        n_ticks++;
        $display("tick %0d act=%0d anim=%0d y=%0d step=%0d face=%0d atk=%0d",
                 n_ticks, action, anim_frame, y_off, step, facing_right, attack_active);
        if (exp_q.size() == 0) begin
          chk("unexpected_tick", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("action",        int'(action),        int'(e.act));
          chk("anim_frame",    int'(anim_frame),    int'(e.anim));
          chk("y_off",         int'(y_off),         int'(e.y));
          chk("step",          int'(step),          int'(e.st));
          chk("facing_right",  int'(facing_right),  int'(e.face));
          chk("attack_active", int'(attack_active), int'(e.atk));
        end
      end
    end
  end

  // hit_mode: 0 none, 1 pulse between ticks, 2 pulse on the tick cycle
  task automatic do_frame(input logic [7:0] key, input int hit_mode);
    model_tick(key, hit_mode != 0);
    @(negedge Clk); keycode = key;
    if (hit_mode == 1) begin hit_in = 1'b1; @(negedge Clk); hit_in = 1'b0; end
    @(negedge Clk); vs = 1'b1;
    @(negedge Clk);                       // frame_tick high during this cycle
    if (hit_mode == 2) hit_in = 1'b1;
    @(negedge Clk); hit_in = 1'b0;        // decision edge has passed
    @(negedge Clk); vs = 1'b0; keycode = 8'($urandom);  // junk between ticks
    @(negedge Clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_action"}, int'(action),        0);
    chk({tag, "_anim"},   int'(anim_frame),    0);
    chk({tag, "_y_off"},  int'(y_off),         0);
    chk({tag, "_step"},   int'(step),          0);
    chk({tag, "_facing"}, int'(facing_right),  1);
    chk({tag, "_atk"},    int'(attack_active), 0);
    chk({tag, "_tick"},   int'(frame_tick),    0);
  endtask

  initial begin
    logic [7:0] keys [7];
    int         r;
    keys = '{8'h00, 8'h04, 8'h07, 8'h1A, 8'h09, 8'h0A, 8'h33};
    model_reset();

    repeat (3) @(negedge Clk);
    chk_reset_outputs("reset");
    Reset = 1'b0;

    // Full jump arc, holding the jump key: take-off, 20 airborne, landing
    do_frame(8'h00, 0);
    repeat (22) do_frame(8'h1A, 0);
    do_frame(8'h00, 0);

    // Punch held: one attack, no retrigger
    repeat (14) do_frame(8'h09, 0);
    do_frame(8'h00, 0);

    // Walk left 5 frames, release, then walk right
    repeat (5) do_frame(8'h04, 0);
    do_frame(8'h00, 0);
    repeat (2) do_frame(8'h07, 0);
    do_frame(8'h00, 0);

    // Kick hit at tick 3, second hit inside hit-stun
    repeat (3) do_frame(8'h0A, 0);
    do_frame(8'h0A, 1);
    repeat (4) do_frame(8'h00, 0);
    do_frame(8'h00, 1);
    repeat (7) do_frame(8'h00, 0);

    // Hits during a jump are ignored, with steering
    do_frame(8'h1A, 0);
    do_frame(8'h1A, 1);
    do_frame(8'h04, 2);
    repeat (19) do_frame(8'h07, ($urandom_range(0, 3) == 0) ? 1 : 0);
    do_frame(8'h00, 0);

    // Hit on the tick cycle while jump key held: hit-stun wins
    do_frame(8'h1A, 2);
    repeat (11) do_frame(8'h00, 0);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 7);
      do_frame(keys[$urandom_range(0, 6)], (r == 0) ? 1 : (r == 1) ? 2 : 0);
    end

    // Reset mid-jump at y_off = 40
    for (int i = 0; i < 30 && m_act != IDLE; i++) do_frame(8'h00, 0);
    do_frame(8'h1A, 0);
    repeat (5) do_frame(8'h1A, 0);
    chk("pre_reset_y_off", int'(y_off), 40);
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk);
    chk_reset_outputs("midjump_reset");
    Reset = 1'b0;
    model_reset();
    repeat (3) do_frame(8'h07, 0);

    repeat (10) @(negedge Clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
